ahb2apb_bridge: RTL and testbench

//  AHB-Lite slave to APB master bridge. Converts single AHB read/write transfers into
//  APB setup/enable cycles toward four APB slaves. Sits between the AHB master
//  and the APB peripheral segment. Inserts AHB wait states via Hreadyout.

---
 rtl/ahb2apb_bridge.sv | 135 +++++++++++++
 tb/tb_ahb2apb_bridge.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge.
// Turns single AHB read/write transfers into APB setup/enable pairs toward
// four APB slaves decoded from Haddr[27:26] inside the 0x8xxx_xxxx window.
// Wait states are inserted through Hreadyout; the response is always OKAY.
module ahb2apb_bridge (
  input  logic        Hclk,
  input  logic        Hrestn,     // synchronous, active-high despite the name
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic [31:0] Hrdata,
  output logic [1:0]  Hresp,
  output logic        Hreadyout,
  input  logic [31:0] Prdata,
  output logic [3:0]  Pselx,
  output logic        Pwrite,
  output logic        Penable,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WWAIT   = 3'd1,
    ST_WRITE   = 3'd2,
    ST_WENABLE = 3'd3,
    ST_READ    = 3'd4,
    ST_RENABLE = 3'd5
  } state_t;

  state_t      state_reg;
  logic [3:0]  sel_reg;
  logic [3:0]  pselx_reg;
  logic        penable_reg;
  logic        hreadyout_reg;
  logic        pwrite_reg;
  logic [31:0] paddr_reg;
  logic [31:0] pwdata_reg;

  logic [3:0]  sel_decode;
  logic        addr_valid;
  logic        can_accept;

  // Hsize and the SEQ/NONSEQ distinction carry no information for 32-bit APB.
  logic        unused_bits;
  assign unused_bits = ^{Hsize, Htrans[0]};

  // One-hot slave select from the 64 MB sub-window the address falls into.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign sel_decode[gi] = (Haddr[27:26] == 2'(gi));
    end
  endgenerate

  // A transfer counts only for NONSEQ/SEQ with the bus ready, inside 0x8xxx_xxxx.
  assign addr_valid = Hreadyin & Htrans[1] & (Haddr[31:28] == 4'h8);

  // Address phases are only taken in the states that drive Hreadyout high.
  assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_RENABLE) ||
                      (state_reg == ST_WENABLE);

  // FSM with outputs registered to match the state being entered.
  always_ff @(posedge Hclk) begin
    if (Hrestn) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= 4'b0000;
      pselx_reg     <= 4'b0000;
      penable_reg   <= 1'b0;
      hreadyout_reg <= 1'b1;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= 32'h0;
      pwdata_reg    <= 32'h0;
    end else begin
      case (state_reg)
        ST_WWAIT: begin
          // Write data arrives one cycle after its address phase.
          pwdata_reg    <= Hwdata;
          state_reg     <= ST_WRITE;
          pselx_reg     <= sel_reg;
          penable_reg   <= 1'b0;
          hreadyout_reg <= 1'b0;
        end
        ST_WRITE: begin
          state_reg     <= ST_WENABLE;
          pselx_reg     <= sel_reg;
          penable_reg   <= 1'b1;
          hreadyout_reg <= 1'b1;
        end
        ST_READ: begin
          state_reg     <= ST_RENABLE;
          pselx_reg     <= sel_reg;
          penable_reg   <= 1'b1;
          hreadyout_reg <= 1'b1;
        end
        default: begin
          // IDLE, RENABLE and WENABLE all pick the next transfer the same way,
          // which gives back-to-back transfers without an IDLE gap.
          if (can_accept && addr_valid) begin
            paddr_reg     <= Haddr;
            pwrite_reg    <= Hwrite;
            sel_reg       <= sel_decode;
            penable_reg   <= 1'b0;
            hreadyout_reg <= 1'b0;
            if (Hwrite) begin
              state_reg <= ST_WWAIT;
              pselx_reg <= 4'b0000;
            end else begin
              state_reg <= ST_READ;
              pselx_reg <= sel_decode;
            end
          end else begin
            state_reg     <= ST_IDLE;
            pselx_reg     <= 4'b0000;
            penable_reg   <= 1'b0;
            hreadyout_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign Pselx     = pselx_reg;
  assign Penable   = penable_reg;
  assign Hreadyout = hreadyout_reg;
  assign Pwrite    = pwrite_reg;
  assign Paddr     = paddr_reg;
  assign Pwdata    = pwdata_reg;
  assign Hrdata    = Prdata;
  assign Hresp     = 2'b00;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed, table-driven bench for ahb2apb_bridge, plus hand-written
// sequences for back-to-back transfers and reset in the middle of a write.
module tb_ahb2apb_bridge;

  logic        Hclk;
  logic        Hrestn;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Hrdata;
  logic [1:0]  Hresp;
  logic        Hreadyout;
  logic [31:0] Prdata;
  logic [3:0]  Pselx;
  logic        Pwrite;
  logic        Penable;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  ahb2apb_bridge dut (
    .Hclk      (Hclk),
    .Hrestn    (Hrestn),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Htrans    (Htrans),
    .Hsize     (Hsize),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .Hrdata    (Hrdata),
    .Hresp     (Hresp),
    .Hreadyout (Hreadyout),
    .Prdata    (Prdata),
    .Pselx     (Pselx),
    .Pwrite    (Pwrite),
    .Penable   (Penable),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        hwrite;
    logic [1:0]  htrans;
    logic        hreadyin;
    logic [31:0] haddr;
    logic [31:0] data;     // Hwdata for writes, Prdata for reads
    logic [3:0]  exp_sel;
    logic        active;   // expect an APB transfer
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] last_paddr;
  logic [31:0] last_pwdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic bus_idle();
    Htrans   = 2'b00;
    Hwrite   = 1'b0;
    Hreadyin = 1'b1;
    Haddr    = 32'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    Hwrite   = v.hwrite;
    Htrans   = v.htrans;
    Hreadyin = v.hreadyin;
    Haddr    = v.haddr;
    Hwdata   = 32'hFFFF_0000;  // garbage during the address phase
    Prdata   = 32'h0BAD_0BAD;
    tick();
    if (!v.active) begin
      chk($sformatf("v%0d ign Pselx", idx), 32'(Pselx), 32'h0);
      chk($sformatf("v%0d ign Penable", idx), 32'(Penable), 32'h0);
      chk($sformatf("v%0d ign Hreadyout", idx), 32'(Hreadyout), 32'h1);
      chk($sformatf("v%0d ign Paddr held", idx), Paddr, last_paddr);
      bus_idle();
      tick();
      $display("vec %0d: addr=0x%08h ignored", idx, v.haddr);
      return;
    end
    last_paddr = v.haddr;
    if (v.hwrite) begin
      // WWAIT
      chk($sformatf("v%0d WWAIT Pselx", idx), 32'(Pselx), 32'h0);
      chk($sformatf("v%0d WWAIT Hreadyout", idx), 32'(Hreadyout), 32'h0);
      bus_idle();
      Hwdata = v.data;
      tick();
      Hwdata = 32'hEEEE_EEEE;
      // WRITE (setup)
      chk($sformatf("v%0d WRITE Pselx", idx), 32'(Pselx), 32'(v.exp_sel));
      chk($sformatf("v%0d WRITE Paddr", idx), Paddr, v.haddr);
      chk($sformatf("v%0d WRITE Pwdata", idx), Pwdata, v.data);
      chk($sformatf("v%0d WRITE Pwrite", idx), 32'(Pwrite), 32'h1);
      chk($sformatf("v%0d WRITE Penable", idx), 32'(Penable), 32'h0);
      chk($sformatf("v%0d WRITE Hreadyout", idx), 32'(Hreadyout), 32'h0);
      tick();
      // WENABLE
      chk($sformatf("v%0d WENABLE Pselx", idx), 32'(Pselx), 32'(v.exp_sel));
      chk($sformatf("v%0d WENABLE Penable", idx), 32'(Penable), 32'h1);
      chk($sformatf("v%0d WENABLE Hreadyout", idx), 32'(Hreadyout), 32'h1);
      last_pwdata = v.data;
    end else begin
      // READ (setup)
      chk($sformatf("v%0d READ Pselx", idx), 32'(Pselx), 32'(v.exp_sel));
      chk($sformatf("v%0d READ Paddr", idx), Paddr, v.haddr);
      chk($sformatf("v%0d READ Pwrite", idx), 32'(Pwrite), 32'h0);
      chk($sformatf("v%0d READ Penable", idx), 32'(Penable), 32'h0);
      chk($sformatf("v%0d READ Hreadyout", idx), 32'(Hreadyout), 32'h0);
      bus_idle();
      Prdata = v.data;
      tick();
      // RENABLE
      chk($sformatf("v%0d RENABLE Pselx", idx), 32'(Pselx), 32'(v.exp_sel));
      chk($sformatf("v%0d RENABLE Penable", idx), 32'(Penable), 32'h1);
      chk($sformatf("v%0d RENABLE Hreadyout", idx), 32'(Hreadyout), 32'h1);
      chk($sformatf("v%0d RENABLE Hrdata", idx), Hrdata, v.data);
      chk($sformatf("v%0d RENABLE Hresp", idx), 32'(Hresp), 32'h0);
    end
    tick();
    // Back in IDLE: selects drop, address/data hold.
    chk($sformatf("v%0d IDLE Pselx", idx), 32'(Pselx), 32'h0);
    chk($sformatf("v%0d IDLE Penable", idx), 32'(Penable), 32'h0);
    chk($sformatf("v%0d IDLE Paddr held", idx), Paddr, last_paddr);
    chk($sformatf("v%0d IDLE Pwdata held", idx), Pwdata, last_pwdata);
    $display("vec %0d: %s addr=0x%08h data=0x%08h sel=%04b", idx,
             v.hwrite ? "write" : "read ", v.haddr, v.data, v.exp_sel);
  endtask

  initial begin
    //            hwrite htrans hrdy haddr          data          sel      active
    vecs[0]  = '{1'b1, 2'b10, 1'b1, 32'h8000_0010, 32'hA5A5_0001, 4'b0001, 1'b1};
    vecs[1]  = '{1'b0, 2'b10, 1'b1, 32'h8400_0020, 32'h1234_5678, 4'b0010, 1'b1};
    vecs[2]  = '{1'b0, 2'b10, 1'b1, 32'h8000_0000, 32'h1111_1111, 4'b0001, 1'b1};
    vecs[3]  = '{1'b0, 2'b10, 1'b1, 32'h8400_0000, 32'h2222_2222, 4'b0010, 1'b1};
    vecs[4]  = '{1'b0, 2'b10, 1'b1, 32'h8800_0000, 32'h3333_3333, 4'b0100, 1'b1};
    vecs[5]  = '{1'b0, 2'b10, 1'b1, 32'h8C00_0000, 32'h4444_4444, 4'b1000, 1'b1};
    vecs[6]  = '{1'b0, 2'b10, 1'b1, 32'h9000_0000, 32'h5555_5555, 4'b0000, 1'b0};
    vecs[7]  = '{1'b1, 2'b11, 1'b1, 32'h8C00_0044, 32'hDEAD_BEEF, 4'b1000, 1'b1};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h8400_0000, 32'h6666_6666, 4'b0000, 1'b0};
    vecs[9]  = '{1'b1, 2'b00, 1'b1, 32'h8000_0000, 32'h7777_7777, 4'b0000, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h8800_0000, 32'h8888_8888, 4'b0000, 1'b0};
    vecs[11] = '{1'b1, 2'b10, 1'b1, 32'h7FFF_FFFC, 32'h9999_9999, 4'b0000, 1'b0};
    vecs[12] = '{1'b1, 2'b10, 1'b1, 32'h8FFF_FFFC, 32'h0BAD_F00D, 4'b1000, 1'b1};

    Hsize  = 3'b010;
    Hwdata = 32'h0;
    Prdata = 32'h0;
    bus_idle();
    last_paddr  = 32'h0;
    last_pwdata = 32'h0;

    // Reset held for two cycles.
    Hrestn = 1'b1;
    tick();
    tick();
    Hrestn = 1'b0;
    chk("rst Pselx", 32'(Pselx), 32'h0);
    chk("rst Penable", 32'(Penable), 32'h0);
    chk("rst Hreadyout", 32'(Hreadyout), 32'h1);
    chk("rst Hresp", 32'(Hresp), 32'h0);
    chk("rst Paddr", Paddr, 32'h0);
    chk("rst Pwdata", Pwdata, 32'h0);
    chk("rst Pwrite", 32'(Pwrite), 32'h0);
    $display("reset: Pselx=%04b Penable=%0b Hreadyout=%0b", Pselx, Penable, Hreadyout);
    tick();

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Back-to-back: read 0x8800_0004, then write 0x8000_0008 presented in RENABLE.
    Htrans = 2'b10; Hwrite = 1'b0; Hreadyin = 1'b1; Haddr = 32'h8800_0004;
    tick();
    chk("b2b READ Pselx", 32'(Pselx), 32'h4);
    chk("b2b READ Hreadyout", 32'(Hreadyout), 32'h0);
    Prdata = 32'hCAFE_0001;
    Hwrite = 1'b1; Haddr = 32'h8000_0008;  // ignored while Hreadyout=0
    tick();
    chk("b2b RENABLE Penable", 32'(Penable), 32'h1);
    chk("b2b RENABLE Hrdata", Hrdata, 32'hCAFE_0001);
    chk("b2b RENABLE Paddr", Paddr, 32'h8800_0004);
    tick();
    chk("b2b WWAIT Pselx", 32'(Pselx), 32'h0);
    chk("b2b WWAIT Hreadyout", 32'(Hreadyout), 32'h0);
    chk("b2b WWAIT Paddr", Paddr, 32'h8000_0008);
    chk("b2b WWAIT Pwrite", 32'(Pwrite), 32'h1);
    bus_idle();
    Hwdata = 32'h55AA_55AA;
    tick();
    chk("b2b WRITE Pselx", 32'(Pselx), 32'h1);
    chk("b2b WRITE Penable", 32'(Penable), 32'h0);
    chk("b2b WRITE Pwdata", Pwdata, 32'h55AA_55AA);
    tick();
    chk("b2b WENABLE Penable", 32'(Penable), 32'h1);
    chk("b2b WENABLE Hreadyout", 32'(Hreadyout), 32'h1);
    tick();
    chk("b2b IDLE Pselx", 32'(Pselx), 32'h0);
    $display("b2b: read 0x88000004 -> write 0x80000008 done");

    // Reset asserted during WRITE aborts before the enable phase.
    Htrans = 2'b10; Hwrite = 1'b1; Hreadyin = 1'b1; Haddr = 32'h8400_0030;
    tick();
    bus_idle();
    Hwdata = 32'h0000_0077;
    tick();
    chk("rstw WRITE Pselx", 32'(Pselx), 32'h2);
    Hrestn = 1'b1;
    tick();
    chk("rstw Pselx", 32'(Pselx), 32'h0);
    chk("rstw Penable", 32'(Penable), 32'h0);
    chk("rstw Hreadyout", 32'(Hreadyout), 32'h1);
    chk("rstw Paddr", Paddr, 32'h0);
    chk("rstw Pwdata", Pwdata, 32'h0);
    Hrestn = 1'b0;
    tick();
    chk("rstw after Penable", 32'(Penable), 32'h0);
    chk("rstw after Pselx", 32'(Pselx), 32'h0);
    $display("reset during write: aborted, Pselx=%04b Penable=%0b", Pselx, Penable);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
